regfile_multiport: RTL and testbench
====================================

# regfile_multiport

Parametrised general-purpose register file for the RV32 core family: configurable register count, data width, read ports and write ports, with x0 hard-wired to zero. Adds a sequential clear engine that zeroes the whole array after reset or on request, gating writes and reads until done. Optional same-cycle write-to-read bypass. Sits between decode (selects) and execute/writeback (data), and is the drop-in generalisation of the single-write, dual-read register file.

## Interface

Parameters:
- XLEN, 32, data width of every register.
- NREGS, 32, number of registers; power of two, ≥4; index 0 is hard-wired zero.
- NREAD, 2, number of read ports, ≥1.
- NWRITE, 1, number of write ports, ≥1.
- AW, $clog2(NREGS), derived; select width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs_sel  in  NREAD*AW  read selects; port p occupies bits [p*AW +: AW].
- rs_out  out  NREAD*XLEN  read data; port p occupies [p*XLEN +: XLEN].
- rd_sel  in  NWRITE*AW  write selects, port w at [w*AW +: AW].
- rd_in  in  NWRITE*XLEN  write data, port w at [w*XLEN +: XLEN].
- rd_w  in  NWRITE  per-port write enable.
- clear_req  in  1  request full array clear.
- ready  out  1  high when array is usable (clear engine idle).

## Operation

- Clear FSM, two states: CLEAR, IDLE.
  - rst asserted: state=CLEAR, clear pointer=1, ready=0, immediately (asynchronous).
  - CLEAR: each cycle writes 0 to register[pointer], pointer+1. After clearing register NREGS-1: state=IDLE, ready=1, pointer back to 1.
  - IDLE: clear_req=1 sampled at a rising edge -> CLEAR with pointer=1, ready=0 from that edge.
  - clear_req while in CLEAR: ignored (no restart).
  - rst mid-clear: restarts at pointer=1.
- Writes (IDLE only): on rising edge, for each port w with rd_w[w]=1 and rd_sel≠0, register[rd_sel] <= rd_in. In CLEAR all write enables are ignored and the data is dropped (no buffering).
- Write collision: several ports same rd_sel same cycle -> highest-index port wins.
- Writes to index 0 discarded; register[0] is never written by any path.
- Reads: combinational. rs_out[p] = 0 if rs_sel[p]==0 or ready==0; else register[rs_sel[p]] (or bypass, below).
- Array contents are not reset directly by rst; they are zeroed only by the clear engine. Before clear completes nothing is observable (reads forced 0).

## Timing

- Reset values: ready=0, rs_out=0 on all ports.
- Clear latency: ready rises NREGS-1 rising edges after rst deasserts (31 for defaults). For clear_req: ready falls at the sampling edge, rises NREGS-1 edges later.
- Write latency: value written at edge N visible on rs_out after edge N (same-cycle visibility only with bypass).
- A write presented in the same cycle clear_req is sampled in IDLE is performed (state still IDLE at that edge); subsequent clear then zeroes it.
- No read latency: rs_out follows rs_sel combinationally.

## Configuration

- REGFILE_BYPASS_EN defined: in IDLE, if any port w has rd_w[w]=1, rd_sel[w]==rs_sel[p]≠0, rs_out[p] = rd_in of the highest such w in the same cycle (combinational forward). Index 0 and ready==0 still force 0.
- Not defined: rs_out always shows the stored value; a same-cycle write becomes visible only after the edge. No forwarding logic synthesised.

## Test plan

- Reset release, defaults: ready=0 and rs_out=0 for 31 edges, ready=1 at edge 31; all 32 registers read 0.
- Write x5=0xDEADBEEF, x0=0x12345678 (NWRITE=1): next cycle rs_sel0=5 -> 0xDEADBEEF, rs_sel1=0 -> 0.
- NWRITE=2, both ports write x7 (0x1111_1111 on port 0, 0x2222_2222 on port 1) same cycle: x7 reads 0x2222_2222.
- clear_req after populating x1..x31 with nonzero values; writes to x3 during CLEAR with rd_w=1: ready low 31 edges, then all registers read 0, x3 =0.
- Bypass: write x10=0xCAFEF00D with rs_sel0=10 same cycle: with REGFILE_BYPASS_EN rs_out0=0xCAFEF00D before the edge; without it, old value (0) before edge, 0xCAFEF00D after.
- rst pulsed at clear pointer=15: ready stays 0, clear restarts, ready rises 31 edges after rst deasserts.

Source files
------------

// File: rtl/regfile_multiport.sv
// Multiport register file with x0 hard-wired to zero and a sequential clear engine.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_multiport #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NWRITE = 1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*AW-1:0]     rs_sel,
    output logic [NREAD*XLEN-1:0]   rs_out,
    input  logic [NWRITE*AW-1:0]    rd_sel,
    input  logic [NWRITE*XLEN-1:0]  rd_in,
    input  logic [NWRITE-1:0]       rd_w,
    input  logic                    clear_req,
    output logic                    ready
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [XLEN-1:0] regs_q [NREGS];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_CLEAR) begin
            if (ptr_q == AW'(NREGS - 1)) begin
                state_d = ST_IDLE;
                ptr_d   = AW'(1);
            end else begin
                ptr_d = ptr_q + AW'(1);
            end
        end else if (clear_req) begin
            state_d = ST_CLEAR;
            ptr_d   = AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Storage is not reset; the clear engine is the only path that zeroes it.
    // Ascending port order lets the highest-index port win a collision.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            regs_q[ptr_q] <= '0;
        end else begin
            for (int w = 0; w < NWRITE; w++) begin
                if (rd_w[w] && (rd_sel[w*AW +: AW] != '0)) begin
                    regs_q[rd_sel[w*AW +: AW]] <= rd_in[w*XLEN +: XLEN];
                end
            end
        end
    end

    assign ready = (state_q == ST_IDLE);

    always_comb begin
        rs_out = '0;
        for (int p = 0; p < NREAD; p++) begin
            if (ready && (rs_sel[p*AW +: AW] != '0)) begin
                rs_out[p*XLEN +: XLEN] = regs_q[rs_sel[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int w = 0; w < NWRITE; w++) begin
                    if (rd_w[w] && (rd_sel[w*AW +: AW] == rs_sel[p*AW +: AW])) begin
                        rs_out[p*XLEN +: XLEN] = rd_in[w*XLEN +: XLEN];
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench for regfile_multiport (2 read, 2 write ports).
module tb_regfile_multiport;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [2*AW-1:0] rs_sel;
    logic [63:0]     rs_out;
    logic [2*AW-1:0] rd_sel;
    logic [63:0]     rd_in;
    logic [1:0]      rd_w;
    logic            clear_req;
    logic            ready;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_multiport #(
        .XLEN   (XLEN),
        .NREGS  (32),
        .NREAD  (2),
        .NWRITE (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rs_sel    (rs_sel),
        .rs_out    (rs_out),
        .rd_sel    (rd_sel),
        .rd_in     (rd_in),
        .rd_w      (rd_w),
        .clear_req (clear_req),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rs_sel = {5'd3, 5'd5};
        repeat (3) tick();
        n_checks++;
        if (ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ready);
        else n_pass++;
        n_checks++;
        if (rs_out !== 64'h0) $display("FAIL reset_rs_out got=%h exp=0", rs_out);
        else n_pass++;
        rst = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            tick();
            n_checks++;
            if (ready !== (i == 31))
                $display("FAIL reset_ready_edge%0d got=%b exp=%b", i, ready, (i == 31));
            else n_pass++;
        end
        for (int i = 0; i < 32; i++) begin
            rs_sel = {i[4:0], i[4:0]};
            #1;
            n_checks++;
            if (rs_out !== 64'h0) $display("FAIL reset_read_x%0d got=%h exp=0", i, rs_out);
            else n_pass++;
        end
    endtask

    task automatic test_write();
        rd_sel = {5'd0, 5'd5};
        rd_in  = {32'h0, 32'hDEADBEEF};
        rd_w   = 2'b01;
        tick();
        rd_sel = {5'd0, 5'd0};
        rd_in  = {32'h0, 32'h12345678};
        tick();
        rd_w   = 2'b00;
        rs_sel = {5'd0, 5'd5};
        #1;
        n_checks++;
        if (rs_out[31:0] !== 32'hDEADBEEF)
            $display("FAIL write_x5 got=%h exp=deadbeef", rs_out[31:0]);
        else n_pass++;
        n_checks++;
        if (rs_out[63:32] !== 32'h0) $display("FAIL write_x0 got=%h exp=0", rs_out[63:32]);
        else n_pass++;
    endtask

    task automatic test_collision();
        rd_sel = {5'd7, 5'd7};
        rd_in  = {32'h2222_2222, 32'h1111_1111};
        rd_w   = 2'b11;
        tick();
        // Distinct targets on both ports in one cycle
        rd_sel = {5'd11, 5'd9};
        rd_in  = {32'hBBBB_0011, 32'hAAAA_0009};
        tick();
        // Only port 0 enabled on a shared target
        rd_sel = {5'd8, 5'd8};
        rd_in  = {32'h4444_4444, 32'h3333_3333};
        rd_w   = 2'b01;
        tick();
        rd_w   = 2'b00;
        rs_sel = {5'd8, 5'd7};
        #1;
        n_checks++;
        if (rs_out[31:0] !== 32'h2222_2222)
            $display("FAIL collision_x7 got=%h exp=22222222", rs_out[31:0]);
        else n_pass++;
        n_checks++;
        if (rs_out[63:32] !== 32'h3333_3333)
            $display("FAIL single_port_x8 got=%h exp=33333333", rs_out[63:32]);
        else n_pass++;
        rs_sel = {5'd11, 5'd9};
        #1;
        n_checks++;
        if (rs_out !== {32'hBBBB_0011, 32'hAAAA_0009})
            $display("FAIL dual_write_x9_x11 got=%h exp=bbbb0011aaaa0009", rs_out);
        else n_pass++;
    endtask

    task automatic test_bypass();
        logic [31:0] exp_fwd;
`ifdef REGFILE_BYPASS_EN
        exp_fwd = 32'hCAFEF00D;
`else
        exp_fwd = 32'h0;
`endif
        rd_sel = {5'd0, 5'd10};
        rd_in  = {32'h0, 32'hCAFEF00D};
        rd_w   = 2'b01;
        rs_sel = {5'd0, 5'd10};
        #1;
        n_checks++;
        if (rs_out[31:0] !== exp_fwd)
            $display("FAIL bypass_before_edge got=%h exp=%h", rs_out[31:0], exp_fwd);
        else n_pass++;
        n_checks++;
        if (rs_out[63:32] !== 32'h0) $display("FAIL bypass_x0 got=%h exp=0", rs_out[63:32]);
        else n_pass++;
        tick();
        rd_w = 2'b00;
        #1;
        n_checks++;
        if (rs_out[31:0] !== 32'hCAFEF00D)
            $display("FAIL bypass_after_edge got=%h exp=cafef00d", rs_out[31:0]);
        else n_pass++;
    endtask

    task automatic test_clear();
        for (int i = 1; i < 32; i++) begin
            rd_sel = {5'd0, i[4:0]};
            rd_in  = {32'h0, 32'h1000_0000 + i};
            rd_w   = 2'b01;
            tick();
        end
        rd_w   = 2'b00;
        rs_sel = {5'd1, 5'd31};
        #1;
        n_checks++;
        if (rs_out !== {32'h1000_0001, 32'h1000_001F})
            $display("FAIL populate got=%h exp=100000011000001f", rs_out);
        else n_pass++;
        // Write sampled at the same edge as clear_req is still performed
        clear_req = 1'b1;
        rd_sel    = {5'd0, 5'd4};
        rd_in     = {32'h0, 32'h0000_ABCD};
        rd_w      = 2'b01;
        tick();
        clear_req = 1'b0;
        rd_sel    = {5'd0, 5'd3};
        rd_in     = {32'h0, 32'hFFFF_FFFF};
        rs_sel    = {5'd0, 5'd3};
        #1;
        n_checks++;
        if (rs_out !== 64'h0) $display("FAIL clear_reads_forced got=%h exp=0", rs_out);
        else n_pass++;
        for (int i = 1; i <= 31; i++) begin
            tick();
            n_checks++;
            if (ready !== (i == 31))
                $display("FAIL clear_ready_edge%0d got=%b exp=%b", i, ready, (i == 31));
            else n_pass++;
            if (i == 9) clear_req = 1'b1;
            if (i == 10) clear_req = 1'b0;
        end
        rd_w = 2'b00;
        for (int i = 0; i < 32; i++) begin
            rs_sel = {i[4:0], i[4:0]};
            #1;
            n_checks++;
            if (rs_out !== 64'h0) $display("FAIL clear_read_x%0d got=%h exp=0", i, rs_out);
            else n_pass++;
        end
    endtask

    task automatic test_rst_mid_clear();
        rd_sel = {5'd0, 5'd20};
        rd_in  = {32'h0, 32'h0000_0055};
        rd_w   = 2'b01;
        tick();
        rd_w   = 2'b00;
        rs_sel = {5'd0, 5'd20};
        #1;
        n_checks++;
        if (rs_out[31:0] !== 32'h55) $display("FAIL pre_rst_x20 got=%h exp=55", rs_out[31:0]);
        else n_pass++;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (14) tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (ready !== 1'b0) $display("FAIL rst_mid_clear_ready got=%b exp=0", ready);
        else n_pass++;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            tick();
            n_checks++;
            if (ready !== (i == 31))
                $display("FAIL restart_ready_edge%0d got=%b exp=%b", i, ready, (i == 31));
            else n_pass++;
        end
        #1;
        n_checks++;
        if (rs_out[31:0] !== 32'h0) $display("FAIL restart_x20 got=%h exp=0", rs_out[31:0]);
        else n_pass++;
        // Asynchronous assertion from IDLE drops ready without a clock edge
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (ready !== 1'b0) $display("FAIL async_rst_ready got=%b exp=0", ready);
        else n_pass++;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        rs_sel    = '0;
        rd_sel    = '0;
        rd_in     = '0;
        rd_w      = '0;
        clear_req = 1'b0;
        test_reset();
        test_write();
        test_collision();
        test_bypass();
        test_clear();
        test_rst_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
